// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared types and constants for the key auto-repeat controller.
//               Provides the controller state encoding, the repeat-acceleration
//               threshold, the interval timer width and a single-key detector.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      REPEAT  = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   // Number of repeat steps after which the faster repeat interval applies
   localparam int ACCEL_THRESH = 8;

   // Width of the interval timer
   localparam int TMR_W = 32;

   // True when exactly one bit of v is set (v is zero-extended by the caller)
   function automatic logic is_single(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_repeat_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat_ctrl
// Description : Converts debounced active-low key levels into single-cycle
//               step pulses. A single key press gives one immediate step;
//               holding it gives auto-repeat steps after DELAY_CYC cycles,
//               then one every RATE_CYC cycles. Chords lock out all steps
//               until every key is released. Keys held through reset are
//               ignored until released.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               key_n    - debounced key levels, 0 = pressed
//               step     - one-cycle step pulse
//               step_idx - index of the key that produced the last step
//               step_rpt - qualifies step as a repeat (not the initial press)
//               busy     - high whenever the controller is not idle
// Options     : KEY_REPEAT_ACCEL_EN - after ACCEL_THRESH repeat steps the
//               repeat interval drops to RATE_CYC/2 (minimum 2) until release
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_ctrl
   import key_pkg::*;
#(
   parameter  int NUM_KEYS  = 4,
   parameter  int DELAY_CYC = 50_000_000,
   parameter  int RATE_CYC  = 10_000_000,
   localparam int IDX_W     = $clog2(NUM_KEYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic                step,
   output logic [IDX_W-1:0]    step_idx,
   output logic                step_rpt,
   output logic                busy
);

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic               step_nxt, rpt_nxt;
   logic [IDX_W-1:0]   idx_nxt;
   logic [NUM_KEYS-1:0] pressed;
   logic [NUM_KEYS-1:0] trk_mask;
   logic               single;
   logic [IDX_W-1:0]   first_idx;
   logic [TMR_W-1:0]   lim_m1;

   assign pressed = ~key_n;
   assign single  = is_single(8'(pressed));
   // step_idx only changes on an initial press, so it names the tracked key
   assign trk_mask = {{(NUM_KEYS-1){1'b0}}, 1'b1} << step_idx;

`ifdef KEY_REPEAT_ACCEL_EN
   localparam int RATE_FAST = ((RATE_CYC / 2) < 2) ? 2 : (RATE_CYC / 2);
   logic [7:0] rpt_cnt, rpt_cnt_nxt;
`endif

   // Position of the pressed key; only meaningful when single is true
   always_comb begin
      first_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pressed[i]) first_idx = IDX_W'(i);
      end
   end

   // Terminal timer value for the current interval
   always_comb begin
      lim_m1 = TMR_W'(DELAY_CYC - 1);
      if (state == REPEAT) begin
`ifdef KEY_REPEAT_ACCEL_EN
         lim_m1 = (rpt_cnt >= 8'(ACCEL_THRESH)) ? TMR_W'(RATE_FAST - 1)
                                                 : TMR_W'(RATE_CYC - 1);
`else
         lim_m1 = TMR_W'(RATE_CYC - 1);
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      step_nxt  = 1'b0;
      rpt_nxt   = 1'b0;
      idx_nxt   = step_idx;
`ifdef KEY_REPEAT_ACCEL_EN
      rpt_cnt_nxt = rpt_cnt;
`endif
      case (state)
         IDLE: begin
            if (single) begin
               state_nxt = DELAY;
               step_nxt  = 1'b1;
               idx_nxt   = first_idx;
               timer_nxt = '0;
`ifdef KEY_REPEAT_ACCEL_EN
               rpt_cnt_nxt = 8'd0;
`endif
            end else if (pressed != '0) begin
               state_nxt = LOCKOUT;
            end
         end
         DELAY, REPEAT: begin
            // Release / chord checks win over a timer expiry in the same cycle
            if (pressed == '0) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (pressed != trk_mask) begin
               state_nxt = LOCKOUT;
               timer_nxt = '0;
            end else if (timer == lim_m1) begin
               state_nxt = REPEAT;
               step_nxt  = 1'b1;
               rpt_nxt   = 1'b1;
               timer_nxt = '0;
`ifdef KEY_REPEAT_ACCEL_EN
               if (rpt_cnt != 8'hFF) rpt_cnt_nxt = rpt_cnt + 8'd1;
`endif
            end else begin
               timer_nxt = timer + TMR_W'(1);
            end
         end
         LOCKOUT: begin
            if (pressed == '0) state_nxt = IDLE;
         end
         default: state_nxt = LOCKOUT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOCKOUT;
         timer    <= '0;
         step     <= 1'b0;
         step_rpt <= 1'b0;
         step_idx <= '0;
         busy     <= 1'b1;
`ifdef KEY_REPEAT_ACCEL_EN
         rpt_cnt  <= 8'd0;
`endif
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         step     <= step_nxt;
         step_rpt <= rpt_nxt;
         step_idx <= idx_nxt;
         busy     <= (state_nxt != IDLE);
`ifdef KEY_REPEAT_ACCEL_EN
         rpt_cnt  <= rpt_cnt_nxt;
`endif
      end
   end

endmodule
`default_nettype wire
